alu_seq: RTL

Parametrised, multi-cycle successor to the 16-bit combinational ALU. It executes the same logic/arithmetic/compare opcode set on WIDTH-bit operands and adds variable-distance shifts. An optional iterative multiplier is available. Operation is under a start/busy/done handshake, and the ZCFNL flags persist in a register, so ADDC/ADDCU consume the stored carry instead of an external carry-in. The block sits between the register file and the writeback stage of the datapath.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_seq_if.sv | 15 +
 rtl/alu_seq_mul.sv | 43 ++++
 rtl/alu_seq.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM state encoding shared by alu_seq and its bench
package alu_pkg;
  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOT   = 4'b0100;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_ADDU  = 4'b0110;
  localparam logic [3:0] OP_ADDC  = 4'b0111;
  localparam logic [3:0] OP_ADDCU = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_LSH   = 4'b1100;
  localparam logic [3:0] OP_RSH   = 4'b1101;
  localparam logic [3:0] OP_ARSH  = 4'b1110;
  localparam logic [3:0] OP_CMPU  = 4'b1111;
  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_L = 0;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_MUL   = 2'd2;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: start/busy/done request bus between the register file side and alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;
  modport master (output start, opcode, a, b, input busy, done, result, flags);
  modport slave (input start, opcode, a, b, output busy, done, result, flags);
endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add unsigned multiplier, one multiplier bit per cycle over WIDTH cycles
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  // prod is the accumulator after this cycle's step, so it is final while done is high
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = busy && cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (load) begin
      busy <= 1'b1;
      acc <= '0;
      mcand <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt <= CW'(WIDTH);
    end else if (busy) begin
      acc <= prod;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt - 1'b1;
      busy <= cnt != CW'(1);
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with persistent ZCFNL flags and bit-serial shifts;
// define ALU_SEQ_MUL_EN to build the iterative multiplier for opcode MUL
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  state_t           state;
  logic [3:0]       op;
  logic [WIDTH-1:0] work, sh_next, res, result, dif;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   cnt, shamt;
  logic [4:0]       flg, flags;
  logic             cin, c, v, n, l, is_cmp, is_shift, done;
  assign shamt = bus.b[SHW-1:0];
  assign is_shift = bus.opcode == OP_LSH || bus.opcode == OP_RSH || bus.opcode == OP_ARSH;
  assign is_cmp = bus.opcode == OP_CMP || bus.opcode == OP_CMPU;
  assign sh_next = op == OP_LSH ? work << 1 : op == OP_RSH ? work >> 1 : {work[WIDTH-1], work[WIDTH-1:1]};
  assign bus.result = result;
  assign bus.flags = flags;
  assign bus.done = done;
  always_comb begin
    cin = (bus.opcode == OP_ADDC || bus.opcode == OP_ADDCU) && flags[FLAG_C];
    sum = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
    dif = bus.a - bus.b;
    res = '0;
    c = 1'b0;
    v = 1'b0;
    n = 1'b0;
    l = 1'b0;
    case (bus.opcode)
      OP_AND: res = bus.a & bus.b;
      OP_OR: res = bus.a | bus.b;
      OP_XOR: res = bus.a ^ bus.b;
      OP_NOT: res = ~bus.a;
      OP_ADD, OP_ADDC: begin
        res = sum[WIDTH-1:0];
        c = bus.opcode == OP_ADDC && sum[WIDTH];
        v = bus.a[WIDTH-1] == bus.b[WIDTH-1] && sum[WIDTH-1] != bus.a[WIDTH-1];
      end
      OP_ADDU, OP_ADDCU: begin
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
      end
      OP_SUB: begin
        res = dif;
        v = bus.a[WIDTH-1] != bus.b[WIDTH-1] && dif[WIDTH-1] != bus.a[WIDTH-1];
      end
      OP_CMP, OP_CMPU: begin
        n = $signed(bus.a) < $signed(bus.b);
        l = bus.a < bus.b;
      end
      OP_LSH, OP_RSH, OP_ARSH: res = bus.a;
      default: res = '0;
    endcase
    flg = {is_cmp ? bus.a == bus.b : res == '0, c, v, n, l};
  end
`ifdef ALU_SEQ_MUL_EN
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] prod;
  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .reset(reset),
    .load(state == S_IDLE && bus.start && bus.opcode == OP_MUL),
    .a(bus.a),
    .b(bus.b),
    .busy(mul_busy),
    .done(mul_done),
    .prod(prod)
  );
  assign bus.busy = state == S_SHIFT || mul_busy;
`else
  assign bus.busy = state != S_IDLE;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      done <= 1'b0;
      result <= '0;
      flags <= '0;
      work <= '0;
      cnt <= '0;
      op <= OP_NOP;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          if (is_shift && shamt != '0) begin
            state <= S_SHIFT;
            work <= bus.a;
            cnt <= shamt;
            op <= bus.opcode;
          end
`ifdef ALU_SEQ_MUL_EN
          else if (bus.opcode == OP_MUL) state <= S_MUL;
`endif
          else begin
            done <= 1'b1;
            if (bus.opcode != OP_NOP && bus.opcode != OP_MUL) begin
              result <= res;
              flags <= flg;
            end
          end
        end
        S_SHIFT: begin
          work <= sh_next;
          cnt <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state <= S_IDLE;
            done <= 1'b1;
            result <= sh_next;
            flags <= {sh_next == '0, 4'b0000};
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: if (mul_done) begin
          state <= S_IDLE;
          done <= 1'b1;
          result <= prod[WIDTH-1:0];
          flags <= {prod[WIDTH-1:0] == '0, prod[2*WIDTH-1:WIDTH] != '0, 3'b000};
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
